signext: RTL and testbench



---
 rtl/legv8_pkg.sv | 22 ++
 rtl/signext_if.sv | 13 +
 rtl/signext_comb.sv | 27 ++
 rtl/signext.sv | 28 ++
 tb/tb_signext.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: opcodes, immediate field positions and
// datapath widths used by the sign-extension unit, main decoder and control.
package legv8_pkg;

  // Datapath widths
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 64;

  // Opcodes recognised by the immediate extractor
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  // D-format DT_address field
  localparam int DT_LSB = 12;
  localparam int DT_W   = 9;

  // CB-format COND_BR_address field
  localparam int CB_LSB = 5;
  localparam int CB_W   = 19;

endpackage

// File: rtl/signext_if.sv
// Decode-stage link into the sign-extension unit: instruction word in,
// registered 64-bit immediate out.
interface signext_if import legv8_pkg::*;;

  logic [INSTR_W-1:0] a;
  logic [IMM_W-1:0]   y;

  // Pipeline side that supplies the instruction and consumes the immediate
  modport master (output a, input y);
  // The sign-extension unit itself
  modport slave  (input a, output y);

endinterface

// File: rtl/signext_comb.sv
// Combinational immediate extractor: picks the D-format or CB-format
// immediate by opcode and sign-extends it by bit replication. Built from
// conditional operators so an unknown opcode bit propagates X to y_next.
module signext_comb import legv8_pkg::*; (
  input  logic [INSTR_W-1:0] a,
  output logic [IMM_W-1:0]   y_next
);

  logic            is_dfmt_s;
  logic            is_cbz_s;
  logic [DT_W-1:0] dt_addr_s;
  logic [CB_W-1:0] cb_addr_s;

  // LDUR and STUR share the same 11-bit opcode slot and extraction
  assign is_dfmt_s = (a[31:21] == OP_LDUR) | (a[31:21] == OP_STUR);
  // CBZ only; CBNZ (0xB5) falls through to zero
  assign is_cbz_s  = (a[31:24] == OP_CBZ);

  assign dt_addr_s = a[DT_LSB +: DT_W];
  assign cb_addr_s = a[CB_LSB +: CB_W];

  // D-format checked first; the two opcode sets are disjoint anyway
  assign y_next = is_dfmt_s ? {{(IMM_W-DT_W){dt_addr_s[DT_W-1]}}, dt_addr_s} :
                  is_cbz_s  ? {{(IMM_W-CB_W){cb_addr_s[CB_W-1]}}, cb_addr_s} :
                              {IMM_W{1'b0}};

endmodule

// File: rtl/signext.sv
// Registered immediate sign-extension unit for the LEGv8 decode stage.
// One-cycle latency, one instruction accepted every cycle, no handshake.
module signext import legv8_pkg::*; (
  input  logic      clk,
  input  logic      reset,
  signext_if.slave  bus
);

  logic [IMM_W-1:0] y_next_s;
  logic [IMM_W-1:0] y_r;

  signext_comb u_comb (
    .a      (bus.a),
    .y_next (y_next_s)
  );

  // Output register; reset wins over any instruction at the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r <= {IMM_W{1'b0}};
    end else begin
      y_r <= y_next_s;
    end
  end

  assign bus.y = y_r;

endmodule

// File: tb/tb_signext.sv
// Scoreboard bench for signext: the driver pushes the expected immediate as
// it applies each word; a monitor pops and compares one cycle later.
module tb_signext;

  logic clk;
  logic reset;

  signext_if bus_i ();

  signext u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          tests;
  int          fails;

  // Reference: decode by opcode value, take the field as an integer and
  // convert it to a signed value with plain arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint      v;
    int unsigned op11;
    int unsigned op8;
    op11 = w >> 21;
    op8  = w >> 24;
    if (op11 == 32'h7C2 || op11 == 32'h7C0) begin
      v = (w >> 12) & 32'd511;
      if (v >= 256) v = v - 512;
    end else if (op8 == 32'hB4) begin
      v = (w >> 5) & 32'h7FFFF;
      if (v >= 262144) v = v - 524288;
    end else begin
      v = 0;
    end
    return v;
  endfunction

  // Apply one word (and reset level) for one cycle and record its expectation
  task automatic apply(input logic rst, input logic [31:0] w,
                       input logic [63:0] exp, input string name);
    reset   = rst;
    bus_i.a = w;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  // Monitor: the unit presents a result every cycle, one edge after the word
  always begin
    logic [63:0] e;
    string       n;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (bus_i.y !== e) begin
        fails++;
        $display("FAIL %s: y=%h expected %h", n, bus_i.y, e);
      end
    end
  end

  initial begin
    logic [31:0] w;
    int          kind;
    logic        r;
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    bus_i.a = 32'h0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state and release
    apply(1'b1, 32'hF8577000, 64'h0, "reset_hold");
    apply(1'b0, 32'hF8577000, 64'hFFFF_FFFF_FFFF_FF77, "reset_release");

    // Directed vectors
    apply(1'b0, 32'hF8477000, 64'h0000_0000_0000_0077, "ldur_pos");
    apply(1'b0, 32'hF8577000, 64'hFFFF_FFFF_FFFF_FF77, "ldur_neg");
    apply(1'b0, 32'hF8077000, 64'h0000_0000_0000_0077, "stur_pos");
    apply(1'b0, 32'hF8177000, 64'hFFFF_FFFF_FFFF_FF77, "stur_neg");
    apply(1'b0, 32'hB46EEEE0, 64'h0000_0000_0003_7777, "cbz_pos");
    apply(1'b0, 32'hB4EEEEE0, 64'hFFFF_FFFF_FFFF_7777, "cbz_neg");
    apply(1'b0, 32'hFFFFFFFF, 64'h0, "all_ones");
    apply(1'b0, 32'h00000000, 64'h0, "all_zeros");
    apply(1'b0, 32'hB56EEEE0, 64'h0, "cbnz");

    // Back-to-back, then don't-care fields changed
    apply(1'b0, 32'hF8477000, 64'h77, "b2b_ldur");
    apply(1'b0, 32'hB46EEEE0, 64'h0000_0000_0003_7777, "b2b_cbz");
    apply(1'b0, 32'hB56EEEE0, 64'h0, "b2b_other");
    apply(1'b0, 32'hF8477FFF, 64'h77, "ldur_rn_rt");
    apply(1'b0, 32'hF8477C1A, 64'h77, "ldur_rn_rt2");
    apply(1'b0, 32'hB46EEEFF, 64'h0000_0000_0003_7777, "cbz_rt");

    // Reset mid-stream discards the in-flight value
    apply(1'b0, 32'hF8577000, 64'hFFFF_FFFF_FFFF_FF77, "pre_reset");
    apply(1'b1, 32'hB4EEEEE0, 64'h0, "mid_reset1");
    apply(1'b1, 32'hF8177000, 64'h0, "mid_reset2");
    apply(1'b0, 32'hB4EEEEE0, 64'hFFFF_FFFF_FFFF_7777, "post_reset");

    // Randomised words biased towards the recognised opcodes
    for (int i = 0; i < 400; i++) begin
      w    = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0:       w[31:21] = 11'h7C2;
        1:       w[31:21] = 11'h7C0;
        2:       w[31:24] = 8'hB4;
        3:       w[31:24] = 8'hB5;
        4:       w[31:21] = 11'h7C2 ^ (11'h1 << $urandom_range(0, 10));
        default: ;
      endcase
      r = ($urandom_range(0, 15) == 0);
      apply(r, w, r ? 64'h0 : ref_imm(w), "random");
    end

    // Drain the scoreboard with a bounded wait
    reset = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
